// File: rtl/finger_dancer_pkg.sv
// rtl/finger_dancer_pkg.sv - shared game states, LFSR taps and display mode encodings
package finger_dancer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PLAY = 3'd2,
    ST_NEXT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Feedback taps b7, b5, b4, b3 of the pattern LFSR
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Display mode as seen by the display block on {C, res}
  localparam logic [1:0] MODE_FAIL  = 2'b00;
  localparam logic [1:0] MODE_PASS  = 2'b01;
  localparam logic [1:0] MODE_SCORE = 2'b10;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  // An all-zero pattern would be unplayable, so it becomes a single finger
  function automatic logic [3:0] pattern_of(input logic [3:0] l);
    return (l == 4'b0000) ? 4'b0001 : l;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - one-bit synchronizer plus stable-count debouncer
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      // Any sample agreeing with the current output restarts the stability run
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        dout <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/finger_judge.sv
// rtl/finger_judge.sv - round pattern generation, hit/miss judging and scoring
module finger_judge
  import finger_dancer_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter int         ROUND_TICKS     = 4,
  parameter int         MAX_MISSES      = 3,
  parameter int         NUM_ROUNDS      = 32,
  parameter int         PASS_SCORE      = 20,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       start,
  input  logic       tick,
  output logic [3:0] pattern,
  output logic [7:0] score,
  output logic       C,
  output logic       res
);

  localparam int TW = $clog2(ROUND_TICKS + 1);
  localparam int MW = $clog2(MAX_MISSES + 1);
  localparam int RW = $clog2(NUM_ROUNDS + 1);

  logic [3:0]    deb;
  state_t        state;
  logic [7:0]    lfsr;
  logic [TW-1:0] tick_cnt;
  logic [MW-1:0] misses;
  logic [RW-1:0] rounds;
  logic          armed;
  logic [1:0]    disp_mode;

  logic          hit;
  logic [7:0]    lfsr_adv;
  logic [RW-1:0] rounds_inc;

  for (genvar gi = 0; gi < 4; gi++) begin : g_db
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk (clk),
      .rst (rst),
      .din (btn[gi]),
      .dout(deb[gi])
    );
  end

  assign hit        = armed && (deb == pattern);
  assign lfsr_adv   = lfsr_next(lfsr);
  assign rounds_inc = rounds + RW'(1);
  assign C          = disp_mode[1];
  assign res        = disp_mode[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      lfsr      <= LFSR_SEED;
      pattern   <= 4'b0000;
      score     <= 8'd0;
      tick_cnt  <= '0;
      misses    <= '0;
      rounds    <= '0;
      armed     <= 1'b0;
      disp_mode <= MODE_SCORE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            score     <= 8'd0;
            misses    <= '0;
            rounds    <= '0;
            lfsr      <= LFSR_SEED;
            disp_mode <= MODE_SCORE;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          lfsr     <= lfsr_adv;
          pattern  <= pattern_of(lfsr_adv[3:0]);
          tick_cnt <= '0;
          armed    <= 1'b0;
          state    <= ST_PLAY;
        end
        ST_PLAY: begin
          if (deb == 4'b0000) armed <= 1'b1;
          // A hit takes priority over a window-closing tick in the same cycle
          if (hit) begin
            if (score != 8'hFF) score <= score + 8'd1;
            pattern <= 4'b0000;
            state   <= ST_NEXT;
          end else if (tick) begin
            if (tick_cnt == TW'(ROUND_TICKS - 1)) begin
              misses  <= misses + MW'(1);
              pattern <= 4'b0000;
              state   <= ST_NEXT;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        ST_NEXT: begin
          rounds <= rounds_inc;
          if (misses == MW'(MAX_MISSES) || rounds_inc == RW'(NUM_ROUNDS)) begin
            disp_mode <= (score >= 8'(PASS_SCORE)) ? MODE_PASS : MODE_FAIL;
            state     <= ST_DONE;
          end else begin
            state <= ST_LOAD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_finger_judge.sv
// tb/tb_finger_judge.sv - directed and random checks of finger_judge against a behavioural model
module tb_finger_judge;

  localparam int         DB   = 4;
  localparam int         RT   = 4;
  localparam int         MM   = 3;
  localparam int         NR   = 8;
  localparam int         PS   = 2;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] pattern;
  logic [7:0] score;
  logic       C;
  logic       res;

  int checks = 0;
  int errors = 0;
  logic chk_on = 1'b0;

  finger_judge #(
    .DEBOUNCE_CYCLES(DB),
    .ROUND_TICKS    (RT),
    .MAX_MISSES     (MM),
    .NUM_ROUNDS     (NR),
    .PASS_SCORE     (PS),
    .LFSR_SEED      (SEED)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn),
    .start  (start),
    .tick   (tick),
    .pattern(pattern),
    .score  (score),
    .C      (C),
    .res    (res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {PH_IDLE, PH_LOAD, PH_PLAY, PH_NEXT, PH_DONE} phase_t;
  phase_t     m_phase = PH_IDLE;
  logic [7:0] m_lfsr = SEED;
  logic [3:0] m_pattern = 4'b0;
  int         m_score = 0;
  logic       m_C = 1'b1;
  logic       m_res = 1'b0;
  int         m_misses = 0;
  int         m_rounds = 0;
  int         m_ticks = 0;
  logic       m_armed = 1'b0;
  logic [3:0] m_s1 = 4'b0;
  logic [3:0] m_s2 = 4'b0;
  logic [3:0] m_deb = 4'b0;
  logic [3:0] m_hist[$];

  task automatic new_game();
    m_score = 0; m_misses = 0; m_rounds = 0;
    m_lfsr = SEED; m_C = 1'b1; m_res = 1'b0;
    m_phase = PH_LOAD;
  endtask

  task automatic model_step();
    logic all_diff;
    if (!rst) begin
      m_s1 = 4'b0; m_s2 = 4'b0; m_deb = 4'b0; m_hist.delete();
      m_phase = PH_IDLE; m_lfsr = SEED; m_pattern = 4'b0; m_score = 0;
      m_C = 1'b1; m_res = 1'b0; m_misses = 0; m_rounds = 0; m_ticks = 0; m_armed = 1'b0;
      return;
    end
    case (m_phase)
      PH_IDLE, PH_DONE: if (start) new_game();
      PH_LOAD: begin
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        m_pattern = (m_lfsr[3:0] == 4'b0) ? 4'b0001 : m_lfsr[3:0];
        m_ticks = 0; m_armed = 1'b0; m_phase = PH_PLAY;
      end
      PH_PLAY: begin
        if (m_armed && m_deb == m_pattern) begin
          if (m_score < 255) m_score++;
          m_pattern = 4'b0; m_phase = PH_NEXT;
        end else if (tick) begin
          m_ticks++;
          if (m_ticks == RT) begin
            m_misses++; m_pattern = 4'b0; m_phase = PH_NEXT;
          end
        end
        if (m_deb == 4'b0) m_armed = 1'b1;
      end
      PH_NEXT: begin
        m_rounds++;
        if (m_misses == MM || m_rounds == NR) begin
          m_C = 1'b0; m_res = (m_score >= PS); m_phase = PH_DONE;
        end else begin
          m_phase = PH_LOAD;
        end
      end
      default: ;
    endcase
    // a debounced bit flips once the last DB synchronized samples all disagree with it
    m_hist.push_back(m_s2);
    if (m_hist.size() > DB) void'(m_hist.pop_front());
    if (m_hist.size() == DB) begin
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        foreach (m_hist[k]) if (m_hist[k][i] == m_deb[i]) all_diff = 1'b0;
        if (all_diff) m_deb[i] = ~m_deb[i];
      end
    end
    m_s2 = m_s1;
    m_s1 = btn;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("pattern", pattern, m_pattern);
      check("score", score, m_score[7:0]);
      check("C", C, m_C);
      check("res", res, m_res);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [3:0] b, input logic s, input logic t);
    btn = b; start = s; tick = t;
    @(negedge clk);
  endtask

  task automatic wait_score(input int exp, input string tag);
    for (int k = 0; k < 30 && score != exp[7:0]; k++) step(btn, 1'b0, 1'b0);
    check(tag, score, exp);
  endtask

  task automatic wait_play();
    for (int k = 0; k < 30 && m_phase != PH_PLAY; k++) step(btn, 1'b0, 1'b0);
    check("reach_play", pattern != 4'b0, 1);
  endtask

  task automatic miss_round(input logic [3:0] b);
    wait_play();
    for (int k = 0; k < RT; k++) begin
      step(b, 1'b0, 1'b1);
      step(b, 1'b0, 1'b0);
    end
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    for (int k = 0; k < n; k++) step(b, 1'b0, 1'b0);
  endtask

  initial begin
    logic t;
    int   len;
    logic [3:0] b;

    rst = 1'b0;
    step(4'b0, 1'b0, 1'b0);
    chk_on = 1'b1;
    step(4'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(4'b0, 1'b0, 1'b0);
    check("rst_pattern", pattern, 4'b0);
    check("rst_score", score, 8'd0);
    check("rst_C", C, 1'b1);
    check("rst_res", res, 1'b0);

    // first round: pattern 1010, stable press scores
    step(4'b0, 1'b1, 1'b0);
    step(4'b0, 1'b0, 1'b0);
    check("first_pattern", pattern, 4'b1010);
    check("first_C", C, 1'b1);
    btn = 4'b1010;
    wait_score(1, "first_hit");
    check("hit_clears_pattern", pattern, 4'b0);
    hold(4'b1010, 2);
    check("second_pattern", pattern, 4'b0101);

    // held fingers and a short glitch must not score
    hold(4'b1010, 10);
    check("held_no_score", score, 8'd1);
    hold(4'b0000, 8);
    step(4'b0101, 1'b0, 1'b0);
    step(4'b0101, 1'b0, 1'b0);
    hold(4'b0000, 10);
    check("glitch_no_hit", score, 8'd1);
    btn = 4'b0101;
    wait_score(2, "rearmed_hit");

    // three misses with score 2 give a pass
    wait_play();
    check("third_pattern", pattern, 4'b1010);
    miss_round(4'b1111);
    check("miss_keeps_score", score, 8'd2);
    miss_round(4'b1111);
    miss_round(4'b1111);
    hold(4'b1111, 1);
    check("pass_C", C, 1'b0);
    check("pass_res", res, 1'b1);
    check("done_pattern", pattern, 4'b0);

    // restart from DONE, one hit then three misses gives a fail
    step(4'b1111, 1'b1, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    check("restart_score", score, 8'd0);
    check("restart_C", C, 1'b1);
    check("restart_pattern", pattern, 4'b1010);
    hold(4'b0000, 8);
    btn = 4'b1010;
    wait_score(1, "fail_game_hit");
    miss_round(4'b0000);
    miss_round(4'b0000);
    miss_round(4'b0000);
    hold(4'b0000, 1);
    check("fail_C", C, 1'b0);
    check("fail_res", res, 1'b0);

    // hit coinciding with the window-closing tick
    step(4'b0, 1'b1, 1'b0);
    step(4'b0, 1'b0, 1'b0);
    for (int k = 0; k < RT - 1; k++) begin
      step(4'b0, 1'b0, 1'b1);
      step(4'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 20; k++) begin
      t = (m_phase == PH_PLAY) && m_armed && (m_deb == m_pattern);
      step(4'b1010, 1'b0, t);
      if (t) break;
    end
    check("hit_on_last_tick", score, 8'd1);
    miss_round(4'b0000);
    miss_round(4'b0000);
    hold(4'b0000, 2);
    check("tie_not_a_miss", C, 1'b1);
    miss_round(4'b0000);
    hold(4'b0000, 1);
    check("third_miss_done", C, 1'b0);

    // reset in the middle of play
    step(4'b0, 1'b1, 1'b0);
    hold(4'b0000, 8);
    btn = 4'b1010;
    wait_score(1, "pre_reset_hit");
    wait_play();
    rst = 1'b0;
    step(4'b0101, 1'b0, 1'b0);
    rst = 1'b1;
    check("midrst_pattern", pattern, 4'b0);
    check("midrst_score", score, 8'd0);
    check("midrst_C", C, 1'b1);
    check("midrst_res", res, 1'b0);
    hold(4'b0000, 8);

    // randomized play, biased toward the current pattern so games progress
    for (int n = 0; n < 3000; n += len) begin
      len = $urandom_range(1, 10);
      case ($urandom_range(0, 3))
        0, 1: b = m_pattern;
        2:    b = 4'b0000;
        default: b = 4'($urandom_range(0, 15));
      endcase
      for (int k = 0; k < len; k++) begin
        rst = ($urandom_range(0, 700) != 0);
        step(b, ($urandom_range(0, 40) == 0), ($urandom_range(0, 5) == 0));
      end
    end
    rst = 1'b1;
    step(4'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
